// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matmul job controller.
package matmul_pkg;

    localparam int WIDTH_DEF = 6;
    localparam int N_DEF     = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        CAPTURE,
        DONE
    } ctrl_state_t;

    function automatic int latency_for(input int n);
        return 3 * n - 1;
    endfunction

endpackage

// File: rtl/matmul_latency_counter.sv
// Cycle counter for the RUN phase: cleared by load, flags its terminal count.
module matmul_latency_counter #(
    parameter int LATENCY = 8,
    parameter int CW      = $clog2(LATENCY) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    logic [CW-1:0] r_count;

    // Saturates at the terminal count so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_count <= '0;
        end else if (i_en && !o_tc) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tc = (r_count == CW'(LATENCY - 1));

endmodule

// File: rtl/matmul_job_controller.sv
// Sequences one matmul job at a time through the systolic datapath.
// Matrices are flat row-major: element (r,c) lives at [(r*N+c)*W +: W].
module matmul_job_controller
    import matmul_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int N       = N_DEF,
    parameter int LATENCY = latency_for(N),
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*N*WIDTH-1:0]       a_in,
    input  logic [N*N*WIDTH-1:0]       b_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N*N*2*WIDTH-1:0]     result_out,
    output logic [N*N*WIDTH-1:0]       dp_a,
    output logic [N*N*WIDTH-1:0]       dp_b,
    output logic                       dp_clear,
    output logic                       dp_start,
    input  logic [N*N*2*WIDTH-1:0]     dp_result,
    output logic                       busy,
    output logic [CNT_W-1:0]           jobs_done
);

    ctrl_state_t                r_state;
    ctrl_state_t                w_next;
    logic                       r_in_ready;
    logic                       r_out_valid;
    logic                       r_dp_clear;
    logic                       r_dp_start;
    logic                       r_busy;
    logic [N*N*WIDTH-1:0]       r_dp_a;
    logic [N*N*WIDTH-1:0]       r_dp_b;
    logic [N*N*2*WIDTH-1:0]     r_result;
    logic [CNT_W-1:0]           r_jobs;
    logic                       w_accept;
    logic                       w_deliver;
    logic                       w_tc;

    assign w_accept  = in_valid && r_in_ready;
    assign w_deliver = r_out_valid && out_ready;

    matmul_latency_counter #(
        .LATENCY (LATENCY)
    ) u_lat_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (r_state == CLEAR),
        .i_en   (r_state == RUN),
        .o_tc   (w_tc)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = CLEAR;
            CLEAR:   w_next = RUN;
            RUN:     if (w_tc) w_next = CAPTURE;
            CAPTURE: w_next = DONE;
            DONE:    if (w_deliver) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake and strobe outputs are decoded from the next state so
    // every port is driven straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_dp_clear  <= 1'b0;
            r_dp_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_dp_a      <= '0;
            r_dp_b      <= '0;
            r_result    <= '0;
            r_jobs      <= '0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == IDLE);
            r_out_valid <= (w_next == DONE);
            r_dp_clear  <= (w_next == CLEAR);
            r_dp_start  <= (r_state == CLEAR);
            r_busy      <= (w_next != IDLE);
            if (w_accept) begin
                r_dp_a <= a_in;
                r_dp_b <= b_in;
            end
            if (r_state == CAPTURE) begin
                r_result <= dp_result;
            end
            if (w_deliver) begin
                r_jobs <= r_jobs + CNT_W'(1);
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign dp_clear   = r_dp_clear;
    assign dp_start   = r_dp_start;
    assign busy       = r_busy;
    assign dp_a       = r_dp_a;
    assign dp_b       = r_dp_b;
    assign result_out = r_result;
    assign jobs_done  = r_jobs;

endmodule

// File: tb/tb_matmul_job_controller.sv
// Directed bench for matmul_job_controller with a behavioural datapath.
module tb_matmul_job_controller;

    localparam int W  = 6;
    localparam int N  = 3;
    localparam int L  = 3 * N - 1;
    localparam int MW = N * N * W;
    localparam int RW = N * N * 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] a_in;
    logic [MW-1:0] b_in;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result_out;
    logic [MW-1:0] dp_a;
    logic [MW-1:0] dp_b;
    logic          dp_clear;
    logic          dp_start;
    logic [RW-1:0] dp_result;
    logic          busy;
    logic [1:0]    jobs_done;

    int            checks = 0;
    int            errors = 0;
    logic [RW-1:0] exp_q[$];
    logic [1:0]    jobs_exp;

    matmul_job_controller #(
        .WIDTH (W),
        .N     (N),
        .CNT_W (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_out (result_out),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_clear   (dp_clear),
        .dp_start   (dp_start),
        .dp_result  (dp_result),
        .busy       (busy),
        .jobs_done  (jobs_done)
    );

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] pk(input int kind, input int v);
        logic [MW-1:0] r;
        int e;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (kind == 0) e = v;
                else if (kind == 1) e = (i == j) ? 1 : 0;
                else e = i * N + j + 1;
                r[(i*N+j)*W +: W] = W'(e);
            end
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] mm(input logic [MW-1:0] a,
                                         input logic [MW-1:0] b);
        logic [RW-1:0]         r;
        logic signed [2*W-1:0] s;
        logic signed [W-1:0]   ea;
        logic signed [W-1:0]   eb;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++) begin
                    ea = a[(i*N+k)*W +: W];
                    eb = b[(k*N+j)*W +: W];
                    s  = s + (2*W)'(ea) * (2*W)'(eb);
                end
                r[(i*N+j)*2*W +: 2*W] = s;
            end
        end
        return r;
    endfunction

    // Datapath stand-in: product settles L cycles after dp_start, junk before.
    logic [3:0] k_cnt;
    always @(posedge clk) begin
        if (rst || dp_clear) k_cnt <= '0;
        else if (dp_start) k_cnt <= 4'd1;
        else if (k_cnt != 0 && k_cnt < 4'(L)) k_cnt <= k_cnt + 4'd1;
    end
    assign dp_result = (k_cnt == 4'(L)) ? mm(dp_a, dp_b) : '1;

    task automatic chk(input string tag, input logic [RW-1:0] obs,
                       input logic [RW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_job(input logic [MW-1:0] a, input logic [MW-1:0] b,
                          input string tag);
        int cyc;
        int clr_n;
        int st_n;
        int clr_at;
        int st_at;
        @(negedge clk);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        out_ready = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_accept"}, in_ready, 1);
        exp_q.push_back(mm(a, b));
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        clr_n = 0;
        st_n = 0;
        clr_at = 0;
        st_at = 0;
        while (!out_valid && cyc < 40) begin
            if (dp_clear) begin clr_n++; clr_at = cyc; end
            if (dp_start) begin st_n++; st_at = cyc; end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, L + 3);
        chk({tag, "_clear_n"}, clr_n, 1);
        chk({tag, "_start_n"}, st_n, 1);
        chk({tag, "_clear_at"}, clr_at, 1);
        chk({tag, "_start_at"}, st_at, 2);
        chk({tag, "_result"}, result_out, exp_q.pop_front());
        @(negedge clk);
        jobs_exp = jobs_exp + 2'd1;
        chk({tag, "_jobs"}, jobs_done, jobs_exp);
        chk({tag, "_ovalid_low"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int            cyc;
        int            bad;
        logic [RW-1:0] held;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        jobs_exp = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_strobes", {dp_clear, dp_start}, 0);
        chk("rst_result", result_out, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_jobs", jobs_done, 0);
        rst = 1'b0;

        do_job(pk(1, 0), pk(2, 0), "ident");
        chk("ident_elem22", result_out[8*2*W +: 2*W], 12'd9);
        do_job(pk(0, 1), pk(0, 1), "ones");
        chk("ones_elem11", result_out[4*2*W +: 2*W], 12'd3);
        do_job(pk(0, -32), pk(0, -32), "wrap");
        chk("wrap_elem00", result_out[0 +: 2*W], 12'hC00);

        // Backpressure with a second job offered while the first is held.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        a_in = pk(0, 2);
        b_in = pk(2, 0);
        exp_q.push_back(mm(a_in, b_in));
        @(negedge clk);
        a_in = pk(2, 0);
        b_in = pk(1, 0);
        exp_q.push_back(mm(a_in, b_in));
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_latency", cyc, L + 3);
        bad = 0;
        held = result_out;
        repeat (20) begin
            if (result_out !== held || in_ready !== 1'b0 ||
                out_valid !== 1'b1 || dp_a !== pk(0, 2)) bad++;
            @(negedge clk);
        end
        chk("bp_hold", bad, 0);
        chk("bp_result1", result_out, exp_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        jobs_exp = jobs_exp + 2'd1;
        chk("bp_jobs1", jobs_done, jobs_exp);
        chk("bp_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_taken", dp_a, pk(2, 0));
        chk("bp_busy", busy, 1);
        out_ready = 1'b1;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_latency2", cyc, L + 3);
        chk("bp_result2", result_out, exp_q.pop_front());
        @(negedge clk);
        jobs_exp = jobs_exp + 2'd1;
        chk("bp_jobs2", jobs_done, jobs_exp);

        // Reset asserted during the fourth RUN cycle.
        @(negedge clk);
        in_valid = 1'b1;
        a_in = pk(0, 1);
        b_in = pk(2, 0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_result", result_out, 0);
        chk("mid_jobs", jobs_done, 0);
        chk("mid_dp_a", dp_a, 0);
        jobs_exp = '0;
        do_job(pk(1, 0), pk(2, 0), "post_rst");

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
